fdc_disk_bridge: RTL and testbench
==================================

# fdc_disk_bridge

Drive-side bridge between the uPD765 FDC core's disk request/completion words and the host block-transfer port (MCU/SD loader). It decodes seek, sector-read, sector-write and next-ID requests from the FDC status word and runs the matching host transaction. It streams 512-byte sector data in either direction, one byte at a time, through the FDC's FIFO strobes. It returns done/error, disk-present and the next sector ID on the FDC control word.

## Interface
- Parameters:
- SECTOR_BYTES, 512, bytes per sector transfer; must be a power of two ≤1024.
- IDTAB_DEPTH, 16, entries in the per-track sector-ID table.
- Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- disk_sr  in  32  FDC request word: [7:0] sector, [14:8] cylinder, [15] head, [17]/[18] read drv0/drv1, [20]/[21] write drv0/drv1, [22] next-ID toggle, [24]/[25] seek drv0/drv1.
- disk_cr  out  32  to FDC: [3] error, [4] done, [5] disk present, [31:24] next sector ID; other bits 0.
- disk_data_in  out  8  read byte into FDC input FIFO.
- disk_data_clkin  out  1  one-cycle write strobe for disk_data_in.
- disk_data_out  in  8  write byte from FDC output FIFO; valid the cycle after disk_data_clkout.
- disk_data_clkout  out  1  one-cycle read strobe to the FDC output FIFO.
- disk_inserted  in  2  per-drive media present.
- host_req  out  1  transaction request; held until host_ack.
- host_op  out  2  0 seek, 1 read, 2 write.
- host_drive, host_head  out  1 each; host_cyl  out  7; host_sector  out  8.
- host_ack  in  1  one-cycle; read: data phase follows; write: data accepted; seek: complete.
- host_err  in  1  sampled with host_ack.
- host_rd_data  in  8; host_rd_valid  in  1.
- host_wr_data  out  8; host_wr_valid  out  1; host_wr_ready  in  1.
- idtab_we  in  1; idtab_addr  in  4; idtab_wdata  in  8; idtab_count  in  5  host-loaded sector-ID list and its length.

## Operation
- States: IDLE, REQ, RD_STREAM, WR_FETCH, WR_HOLD, WR_WAIT, DONE.
- IDLE: the block accepts a request when any of bits 17,18,20,21,24,25 is set and disk_cr[4]=0.
- Priority: seek, then read, then write. Drive 0 wins over drive 1.
- On accept, latch the drive, head, cylinder and sector, and set host_op.
- Seek and read go to REQ. Write goes to WR_FETCH.
- Disk absent: if disk_inserted[drive]=0, go straight to DONE with error=1 and issue no host_req.
- REQ: hold host_req high.
  - On host_ack with host_err: go to DONE, error=1.
  - Seek ack: go to DONE, error=0, and reset the ID index to 0.
  - Read ack: go to RD_STREAM.
- RD_STREAM: each host_rd_valid produces disk_data_clkin=1 with disk_data_in=host_rd_data in the next cycle.
  - The byte counter counts SECTOR_BYTES bytes, then goes to DONE.
  - host_rd_valid seen in any other state is dropped.
- WR_FETCH: pulse disk_data_clkout, then go to WR_HOLD.
- WR_HOLD: capture disk_data_out, drive host_wr_valid=1, and hold it until host_wr_ready.
  - After the last byte go to REQ with host_op=2.
  - Otherwise go back to WR_FETCH.
  - The write ack/err is then handled as for read, but goes straight to DONE.
- DONE: disk_cr[4]=1 and disk_cr[3]=error.
  - Hold until all request bits (17,18,20,21,24,25) are 0, then clear done/error and go to IDLE.
- Next-ID:
  - Any change of disk_sr[22], in any state, advances the index modulo idtab_count.
  - disk_cr[31:24] = table[index].
  - idtab_count=0 forces 0x00.
  - An idtab write while the index advances: both take effect; the read-out reflects the write in the next cycle.
- disk_cr[5] = disk_inserted[last latched drive]. The latched drive resets to 0.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, index 0, byte counter 0.
  - The disk_sr[22] history register loads disk_sr[22] on the first clock after reset, so no spurious advance occurs.
- Request latency: host_req rises 1 cycle after the request bit is sampled.
- Read streaming: 1-cycle latency from host_rd_valid to disk_data_clkin, one byte per cycle sustained.
- Write streaming: 3 cycles minimum per byte (fetch, capture/hold, ready).
- Done: rises 1 cycle after the final byte, ack or error. It falls 1 cycle after the request bits clear.
- Request bits that drop mid-operation abort nothing. The transaction completes, then DONE clears immediately.
- Byte counter is log2(SECTOR_BYTES)+1 bits wide. Terminal condition is count==SECTOR_BYTES-1 with a strobe; there is no wrap.
- Reset mid-stream abandons the transfer and drops host_req and host_wr_valid asynchronously.

## Structure
- fdc_bridge_pkg: disk_sr/disk_cr bit-position constants, host_op encodings, state enum.
- Sub-module fdc_idtab: IDTAB_DEPTH×8 register file plus index counter and toggle edge detect.
- Top holds the FSM, byte counter and strobe generation.

## Test plan
- Seek on drive 0: disk_sr[24]=1, cyl 0x05 -> host_req, op=0, host_cyl=5; ack -> disk_cr[4]=1, [3]=0; clear bit 24 -> done low next cycle.
- Sector read: disk_sr={head 0, cyl 2, sector 0xC1, bit17}, host sends bytes 0..511 at full rate -> 512 disk_data_clkin pulses carrying matching data, then done=1.
- Sector write: FDC FIFO preloaded with 0xAA,0x55,… and host_wr_ready toggled randomly -> 512 host_wr_valid handshakes, byte order preserved, then host_req op=2; ack -> done.
- Error paths:
  - Read with host_err=1 on ack -> done=1, error=1, zero clkin pulses.
  - Request with disk_inserted[0]=0 -> done/error within 2 cycles, no host_req.
- ID table: load C1,C6,C2 with count 3 -> six toggles of bit 22 give C6,C2,C1,C6,C2,C1 on disk_cr[31:24]; a seek then restores C1.
- Async reset asserted at byte 200 of a read -> all outputs 0 immediately; a subsequent read completes normally.

Source files
------------

// File: rtl/fdc_bridge_pkg.sv
// Shared constants, host op codes and FSM states for the FDC disk bridge.
// Bit positions follow the uPD765 core's disk_sr / disk_cr words.
package fdc_bridge_pkg;

  localparam int SR_HEAD = 15;
  localparam int SR_RD0  = 17;
  localparam int SR_RD1  = 18;
  localparam int SR_WR0  = 20;
  localparam int SR_WR1  = 21;
  localparam int SR_TOG  = 22;
  localparam int SR_SK0  = 24;
  localparam int SR_SK1  = 25;

  localparam int CR_ERR  = 3;
  localparam int CR_DONE = 4;
  localparam int CR_PRES = 5;

  typedef enum logic [1:0] {
    OP_SEEK  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } host_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD_STREAM,
    ST_WR_FETCH,
    ST_WR_HOLD,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic     vld;
    host_op_e op;
    logic     drv;
  } req_t;

  function automatic logic any_req(input logic [31:0] sr);
    return sr[SR_RD0] | sr[SR_RD1] | sr[SR_WR0] |
           sr[SR_WR1] | sr[SR_SK0] | sr[SR_SK1];
  endfunction

  // Seek beats read beats write; drive 0 beats drive 1.
  function automatic req_t decode_req(input logic [31:0] sr);
    req_t r;
    r = '{vld: 1'b0, op: OP_SEEK, drv: 1'b0};
    if (sr[SR_SK0])      r = '{1'b1, OP_SEEK,  1'b0};
    else if (sr[SR_SK1]) r = '{1'b1, OP_SEEK,  1'b1};
    else if (sr[SR_RD0]) r = '{1'b1, OP_READ,  1'b0};
    else if (sr[SR_RD1]) r = '{1'b1, OP_READ,  1'b1};
    else if (sr[SR_WR0]) r = '{1'b1, OP_WRITE, 1'b0};
    else if (sr[SR_WR1]) r = '{1'b1, OP_WRITE, 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/fdc_disk_bridge_if.sv
// FDC-side and host-side signal bundle of the disk bridge.
// master is the bridge, slave is the FDC core plus host loader.
interface fdc_disk_bridge_if;

  logic [31:0] disk_sr;
  logic [31:0] disk_cr;
  logic [7:0]  disk_data_in;
  logic        disk_data_clkin;
  logic [7:0]  disk_data_out;
  logic        disk_data_clkout;
  logic [1:0]  disk_inserted;

  logic        host_req;
  logic [1:0]  host_op;
  logic        host_drive;
  logic        host_head;
  logic [6:0]  host_cyl;
  logic [7:0]  host_sector;
  logic        host_ack;
  logic        host_err;
  logic [7:0]  host_rd_data;
  logic        host_rd_valid;
  logic [7:0]  host_wr_data;
  logic        host_wr_valid;
  logic        host_wr_ready;

  logic        idtab_we;
  logic [3:0]  idtab_addr;
  logic [7:0]  idtab_wdata;
  logic [4:0]  idtab_count;

  modport master (
    input  disk_sr, disk_data_out, disk_inserted,
    input  host_ack, host_err, host_rd_data,
    input  host_rd_valid, host_wr_ready,
    input  idtab_we, idtab_addr, idtab_wdata,
    input  idtab_count,
    output disk_cr, disk_data_in, disk_data_clkin,
    output disk_data_clkout,
    output host_req, host_op, host_drive,
    output host_head, host_cyl, host_sector,
    output host_wr_data, host_wr_valid
  );

  modport slave (
    output disk_sr, disk_data_out, disk_inserted,
    output host_ack, host_err, host_rd_data,
    output host_rd_valid, host_wr_ready,
    output idtab_we, idtab_addr, idtab_wdata,
    output idtab_count,
    input  disk_cr, disk_data_in, disk_data_clkin,
    input  disk_data_clkout,
    input  host_req, host_op, host_drive,
    input  host_head, host_cyl, host_sector,
    input  host_wr_data, host_wr_valid
  );

endinterface

// File: rtl/fdc_idtab.sv
// Per-track sector-ID table with a toggle-driven read index.
// The toggle history is primed on the first clock after reset.
module fdc_idtab #(
  parameter int IDTAB_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [3:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] count_i,
  input  logic       tog_i,
  input  logic       clr_i,
  output logic [7:0] id_o
);

  localparam int IW =
    (IDTAB_DEPTH > 1) ? $clog2(IDTAB_DEPTH) : 1;

  logic [7:0]    tab_q [IDTAB_DEPTH];
  logic [IW-1:0] idx_q, idx_d;
  logic          tog_q;
  logic          primed_q;
  logic          adv;
  logic [4:0]    nxt;

  assign adv = primed_q & (tog_i ^ tog_q);
  assign nxt = 5'(idx_q) + 5'd1;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)
      idx_d = '0;
    else if (adv)
      idx_d = (nxt >= count_i) ? '0 : IW'(nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IDTAB_DEPTH; i++)
        tab_q[i] <= '0;
      idx_q    <= '0;
      tog_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      if (we_i)
        tab_q[IW'(addr_i)] <= wdata_i;
      idx_q    <= idx_d;
      tog_q    <= tog_i;
      primed_q <= 1'b1;
    end
  end

  assign id_o = (count_i == '0) ? 8'h00 : tab_q[idx_q];

endmodule

// File: rtl/fdc_disk_bridge.sv
// uPD765 disk request decoder and host block-transfer sequencer.
// Streams one sector per request, byte-wise, via the FDC FIFO strobes.
module fdc_disk_bridge
  import fdc_bridge_pkg::*;
#(
  parameter int SECTOR_BYTES = 512,
  parameter int IDTAB_DEPTH  = 16
) (
  input logic               clk,
  input logic               rst_n,
  fdc_disk_bridge_if.master bus
);

  localparam int CW = $clog2(SECTOR_BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(SECTOR_BYTES - 1);

  state_e        state_q, state_d;
  host_op_e      op_q, op_d;
  logic          drv_q, drv_d;
  logic          head_q, head_d;
  logic [6:0]    cyl_q, cyl_d;
  logic [7:0]    sec_q, sec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [7:0]    wdat_q, wdat_d;
  logic [7:0]    rdat_q;
  logic          clkin_q;
  logic          pres_q;
  logic          seek_clr;
  logic [7:0]    next_id;
  req_t          dec;
  logic          unused_sr;

  assign dec = decode_req(bus.disk_sr);
  assign unused_sr = ^{bus.disk_sr[31:26],
                       bus.disk_sr[23],
                       bus.disk_sr[19],
                       bus.disk_sr[16]};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    drv_d    = drv_q;
    head_d   = head_q;
    cyl_d    = cyl_q;
    sec_d    = sec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wdat_d   = wdat_q;
    seek_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dec.vld) begin
          op_d   = dec.op;
          drv_d  = dec.drv;
          head_d = bus.disk_sr[SR_HEAD];
          cyl_d  = bus.disk_sr[14:8];
          sec_d  = bus.disk_sr[7:0];
          cnt_d  = '0;
          err_d  = 1'b0;
          if (!bus.disk_inserted[dec.drv]) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (dec.op == OP_WRITE) begin
            state_d = ST_WR_FETCH;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.host_ack) begin
          if (bus.host_err) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (op_q == OP_READ) begin
            state_d = ST_RD_STREAM;
          end else begin
            state_d  = ST_DONE;
            seek_clr = (op_q == OP_SEEK);
          end
        end
      end
      ST_RD_STREAM: begin
        if (bus.host_rd_valid) begin
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_WR_FETCH: state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        wdat_d  = bus.disk_data_out;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (bus.host_wr_ready) begin
          if (cnt_q == LAST) begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end else begin
            state_d = ST_WR_FETCH;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        if (!any_req(bus.disk_sr)) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SEEK;
      drv_q   <= 1'b0;
      head_q  <= 1'b0;
      cyl_q   <= '0;
      sec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      clkin_q <= 1'b0;
      pres_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      drv_q   <= drv_d;
      head_q  <= head_d;
      cyl_q   <= cyl_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wdat_q  <= wdat_d;
      pres_q  <= bus.disk_inserted[drv_q];
      // Read bytes reach the FDC exactly one cycle after the host offers them.
      clkin_q <= (state_q == ST_RD_STREAM) & bus.host_rd_valid;
      if ((state_q == ST_RD_STREAM) && bus.host_rd_valid)
        rdat_q <= bus.host_rd_data;
    end
  end

  fdc_idtab #(
    .IDTAB_DEPTH(IDTAB_DEPTH)
  ) u_idtab (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bus.idtab_we),
    .addr_i  (bus.idtab_addr),
    .wdata_i (bus.idtab_wdata),
    .count_i (bus.idtab_count),
    .tog_i   (bus.disk_sr[SR_TOG]),
    .clr_i   (seek_clr),
    .id_o    (next_id)
  );

  always_comb begin
    bus.disk_cr          = '0;
    bus.disk_cr[31:24]   = next_id;
    bus.disk_cr[CR_PRES] = pres_q;
    bus.disk_cr[CR_DONE] = (state_q == ST_DONE);
    bus.disk_cr[CR_ERR]  = (state_q == ST_DONE) & err_q;
  end

  assign bus.disk_data_in     = rdat_q;
  assign bus.disk_data_clkin  = clkin_q;
  assign bus.disk_data_clkout = (state_q == ST_WR_FETCH);
  assign bus.host_req         = (state_q == ST_REQ);
  assign bus.host_op          = op_q;
  assign bus.host_drive       = drv_q;
  assign bus.host_head        = head_q;
  assign bus.host_cyl         = cyl_q;
  assign bus.host_sector      = sec_q;
  assign bus.host_wr_data     = wdat_q;
  assign bus.host_wr_valid    = (state_q == ST_WR_WAIT);

endmodule

// File: tb/tb_fdc_disk_bridge.sv
// Scoreboard bench for fdc_disk_bridge: tasks queue expected events,
// negedge monitors pop and compare them as the bridge produces them.
module tb_fdc_disk_bridge;

  localparam int SB = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fdc_disk_bridge_if bus();

  fdc_disk_bridge #(
    .SECTOR_BYTES(SB),
    .IDTAB_DEPTH (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_req_q[$];
  logic [7:0]  exp_in_q[$];
  logic [7:0]  exp_wr_q[$];
  logic        exp_done_q[$];
  logic [7:0]  fdc_fifo[$];

  logic [7:0] m_tab[16];
  int         m_idx = 0;
  int         m_cnt = 0;
  logic       tog = 1'b0;
  bit         wr_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FDC output FIFO and randomly stalling host write port.
  always @(posedge clk) begin
    if (bus.disk_data_clkout && fdc_fifo.size() > 0)
      bus.disk_data_out <= fdc_fifo.pop_front();
    bus.host_wr_ready <= wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  logic req_prev  = 1'b0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.disk_data_clkin) begin
      if (exp_in_q.size() == 0) chk("unexpected clkin", 1, 0);
      else chk("clkin data", bus.disk_data_in, exp_in_q.pop_front());
    end
    if (bus.host_wr_valid && bus.host_wr_ready) begin
      if (exp_wr_q.size() == 0) chk("unexpected wr beat", 1, 0);
      else chk("wr data", bus.host_wr_data, exp_wr_q.pop_front());
    end
    if (bus.host_req && !req_prev) begin
      if (exp_req_q.size() == 0) chk("unexpected host_req", 1, 0);
      else chk("host_req fields",
               {bus.host_op, bus.host_drive, bus.host_head,
                bus.host_cyl, bus.host_sector},
               exp_req_q.pop_front());
    end
    if (bus.disk_cr[4] && !done_prev) begin
      if (exp_done_q.size() == 0) chk("unexpected done", 1, 0);
      else chk("done error bit", bus.disk_cr[3], exp_done_q.pop_front());
    end
    req_prev  <= bus.host_req;
    done_prev <= bus.disk_cr[4];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_id();
    return (m_cnt == 0) ? 8'h00 : m_tab[m_idx];
  endfunction

  function automatic void m_toggle();
    m_idx = (m_cnt == 0) ? 0 : (m_idx + 1) % m_cnt;
  endfunction

  // Request priority as an ordered table: {valid, op, drive}.
  function automatic logic [3:0] m_decode(input logic [31:0] sr);
    int pos[6] = '{24, 25, 17, 18, 20, 21};
    for (int k = 0; k < 6; k++)
      if (sr[pos[k]]) return {1'b1, 2'(k / 2), 1'(k % 2)};
    return 4'b0;
  endfunction

  task automatic push_req(input logic [31:0] sr);
    logic [3:0] d;
    d = m_decode(sr);
    exp_req_q.push_back({d[2:1], d[0], sr[15], sr[14:8], sr[7:0]});
  endtask

  task automatic set_sr(input logic [31:0] bits);
    bus.disk_sr = bits | (32'(tog) << 22);
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!bus.host_req && n < maxc) begin step(); n++; end
    chk("host_req seen", bus.host_req, 1);
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!bus.disk_cr[4] && n < maxc) begin step(); n++; end
    chk("done seen", bus.disk_cr[4], 1);
  endtask

  task automatic do_ack(input logic e);
    bus.host_ack = 1'b1;
    bus.host_err = e;
    step();
    bus.host_ack = 1'b0;
    bus.host_err = 1'b0;
  endtask

  task automatic release_sr();
    set_sr(32'h0);
    step();
    chk("done falls", bus.disk_cr[4], 0);
  endtask

  task automatic do_seek(input logic drv, input logic [6:0] cyl);
    logic [31:0] sr;
    sr = (drv ? 32'h1 << 25 : 32'h1 << 24) | (32'(cyl) << 8);
    push_req(sr);
    exp_done_q.push_back(1'b0);
    set_sr(sr);
    wait_req(4);
    do_ack(1'b0);
    m_idx = 0;
    wait_done(4);
    chk("id after seek", bus.disk_cr[31:24], m_id());
    release_sr();
  endtask

  task automatic do_read(input logic drv, input logic head,
                         input logic [6:0] cyl, input logic [7:0] sec,
                         input logic err, input bit rnd,
                         input int abort_at);
    logic [31:0] sr;
    logic [7:0]  b;
    sr = (drv ? 32'h1 << 18 : 32'h1 << 17) | (32'(head) << 15) |
         (32'(cyl) << 8) | 32'(sec);
    push_req(sr);
    set_sr(sr);
    wait_req(4);
    if (err) begin
      exp_done_q.push_back(1'b1);
      do_ack(1'b1);
      wait_done(2);
      chk("err read done err", bus.disk_cr[3], 1);
      release_sr();
      return;
    end
    do_ack(1'b0);
    if (abort_at < 0) exp_done_q.push_back(1'b0);
    for (int i = 0; i < SB; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        bus.host_rd_valid = 1'b0;
        return;
      end
      b = rnd ? 8'($urandom) : 8'(i);
      exp_in_q.push_back(b);
      bus.host_rd_valid = 1'b1;
      bus.host_rd_data  = b;
      step();
    end
    bus.host_rd_valid = 1'b0;
    chk("read done at once", bus.disk_cr[4], 1);
    wait_done(2);
    release_sr();
  endtask

  task automatic do_write(input logic drv, input logic [6:0] cyl,
                          input logic [7:0] sec);
    logic [31:0] sr;
    logic [7:0]  b;
    sr = (drv ? 32'h1 << 21 : 32'h1 << 20) | (32'(cyl) << 8) | 32'(sec);
    for (int i = 0; i < SB; i++) begin
      b = (i[0] ? 8'h55 : 8'hAA) ^ 8'(i >> 1);
      fdc_fifo.push_back(b);
      exp_wr_q.push_back(b);
    end
    push_req(sr);
    exp_done_q.push_back(1'b0);
    wr_rand = 1'b1;
    set_sr(sr);
    wait_req(SB * 24);
    wr_rand = 1'b0;
    chk("write beats drained", exp_wr_q.size(), 0);
    do_ack(1'b0);
    wait_done(2);
    release_sr();
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.disk_cr, bus.disk_data_in, bus.disk_data_clkin,
            bus.disk_data_clkout, bus.host_req, bus.host_op,
            bus.host_drive, bus.host_head, bus.host_cyl[3:0],
            bus.host_sector ^ bus.host_wr_data, bus.host_wr_valid} |
           64'(bus.host_cyl[6:4]);
  endfunction

  initial begin
    logic [7:0] ids[3] = '{8'hC1, 8'hC6, 8'hC2};
    int a;
    for (int i = 0; i < 16; i++) m_tab[i] = 8'h00;
    bus.disk_sr       = '0;
    bus.disk_inserted = 2'b11;
    bus.host_ack      = 1'b0;
    bus.host_err      = 1'b0;
    bus.host_rd_data  = '0;
    bus.host_rd_valid = 1'b0;
    bus.idtab_we      = 1'b0;
    bus.idtab_addr    = '0;
    bus.idtab_wdata   = '0;
    bus.idtab_count   = '0;
    #3;
    chk("reset outputs", all_outs(), 0);
    chk("reset cr", bus.disk_cr, 0);
    step(); step();
    rst_n = 1'b1;
    step(); step();

    do_seek(1'b0, 7'h05);
    do_read(1'b0, 1'b0, 7'd2, 8'hC1, 1'b0, 1'b0, -1);
    do_read(1'b1, 1'b1, 7'd40, 8'h03, 1'b0, 1'b1, -1);
    do_write(1'b0, 7'd9, 8'hC2);
    do_read(1'b0, 1'b0, 7'd3, 8'hC4, 1'b1, 1'b0, -1);

    // Absent media: done/error without a host transaction.
    bus.disk_inserted = 2'b10;
    exp_done_q.push_back(1'b1);
    set_sr(32'h1 << 17);
    step(); step();
    chk("absent done", bus.disk_cr[4], 1);
    chk("absent err", bus.disk_cr[3], 1);
    chk("absent present", bus.disk_cr[5], 0);
    release_sr();
    bus.disk_inserted = 2'b11;

    // Priority: seek drive 1 outranks read and write on drive 0.
    push_req((32'h1 << 25) | (32'h1 << 17) | (32'h1 << 20) | 32'h0300);
    exp_done_q.push_back(1'b0);
    set_sr((32'h1 << 25) | (32'h1 << 17) | (32'h1 << 20) | 32'h0300);
    wait_req(4);
    chk("prio op", bus.host_op, 0);
    chk("prio drive", bus.host_drive, 1);
    do_ack(1'b0);
    m_idx = 0;
    wait_done(2);
    release_sr();
    chk("present drv1", bus.disk_cr[5], 1);
    bus.disk_inserted = 2'b01;
    step();
    chk("absent drv1", bus.disk_cr[5], 0);
    bus.disk_inserted = 2'b11;

    // Sector-ID table.
    for (int k = 0; k < 3; k++) begin
      bus.idtab_we    = 1'b1;
      bus.idtab_addr  = 4'(k);
      bus.idtab_wdata = ids[k];
      m_tab[k] = ids[k];
      step();
    end
    bus.idtab_we    = 1'b0;
    bus.idtab_count = 5'd3;
    m_cnt = 3;
    step();
    chk("id start", bus.disk_cr[31:24], m_id());
    for (int t = 0; t < 6; t++) begin
      tog = ~tog;
      set_sr(32'h0);
      m_toggle();
      step();
      chk("id toggle", bus.disk_cr[31:24], m_id());
    end
    tog = ~tog;
    set_sr(32'h0);
    m_toggle();
    step();
    chk("id pre-seek", bus.disk_cr[31:24], m_id());
    do_seek(1'b0, 7'h11);
    chk("id restored", bus.disk_cr[31:24], 8'hC1);
    bus.idtab_count = 5'd0;
    m_cnt = 0;
    step();
    chk("id count0", bus.disk_cr[31:24], 8'h00);
    bus.idtab_count = 5'd3;
    m_cnt = 3;
    a = (m_idx + 1) % 3;
    tog = ~tog;
    set_sr(32'h0);
    bus.idtab_we    = 1'b1;
    bus.idtab_addr  = 4'(a);
    bus.idtab_wdata = 8'h5A;
    m_tab[a] = 8'h5A;
    m_toggle();
    step();
    bus.idtab_we = 1'b0;
    chk("id write+adv", bus.disk_cr[31:24], m_id());

    // Reset in the middle of a read, then a clean read.
    do_read(1'b0, 1'b0, 7'd6, 8'hC1, 1'b0, 1'b1, 200);
    #1;
    chk("midreset outputs", all_outs(), 0);
    chk("midreset cr", bus.disk_cr, 0);
    exp_in_q.delete();
    for (int i = 0; i < 16; i++) m_tab[i] = 8'h00;
    m_idx = 0;
    set_sr(32'h0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    do_read(1'b0, 1'b0, 7'd6, 8'hC1, 1'b0, 1'b1, -1);
    chk("id after reset", bus.disk_cr[31:24], m_id());

    step(); step();
    chk("queues drained",
        exp_req_q.size() + exp_in_q.size() + exp_wr_q.size() +
        exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
